tl_wrr_scheduler: RTL and testbench

- Weighted round-robin scheduler between the four input class FIFOs and the four output class FIFOs of the transaction layer.
- Each cycle it selects at most one non-empty input queue whose destination output FIFO is not almost-full, and pops that queue.
- One cycle later it pushes the popped word into the destination FIFO.
- It runs only while the link state machine reports ACTIVE, and reports idle back to it.

---
 rtl/tl_pkg.sv | 22 ++
 rtl/tl_rr_pick.sv | 31 +++
 rtl/tl_wrr_scheduler.sv | 127 ++++++++++++
 tb/tb_tl_wrr_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared constants, state encoding and helpers for the
// transaction-layer weighted round-robin scheduler.
package tl_pkg;

  localparam int NUM_Q    = 4;
  localparam int CLASS_W  = 2;
  localparam int WEIGHT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  // Extract the burst weight configured for queue q.
  function automatic logic [WEIGHT_W-1:0] weight_of(
    input logic [NUM_Q*WEIGHT_W-1:0] cfg,
    input logic [1:0]                q
  );
    weight_of = cfg[q*WEIGHT_W +: WEIGHT_W];
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Rotating-priority find-first over four request lines:
// search order is start, start+1, start+2, start+3 (mod 4).
module tl_rr_pick (
  input  logic [3:0] elig,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  assign dbl   = {elig, elig};
  assign rot   = dbl[start +: 4];
  assign found = |rot;
  assign idx   = start + off;

  // Lowest set bit of the rotated vector is the winner offset.
  always_comb begin
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

endmodule

// File: rtl/tl_wrr_scheduler.sv
// Weighted round-robin mover from input class FIFOs to output
// class FIFOs: pop in cycle N, push to head class in cycle N+1.
module tl_wrr_scheduler
  import tl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_Q*WEIGHT_W-1:0] weight_cfg,
  input  logic [NUM_Q-1:0]          empty_in,
  input  logic [NUM_Q*CLASS_W-1:0]  head_class,
  input  logic [NUM_Q-1:0]          almost_full_out,
  output logic [NUM_Q-1:0]          pop_in,
  output logic [NUM_Q-1:0]          push_out,
  output logic [1:0]                grant_id,
  output logic                      idle
);

  sched_state_e          state;
  sched_state_e          state_d;
  logic [NUM_Q-1:0]      elig;
  logic [1:0]            ptr;
  logic [WEIGHT_W-1:0]   credit;
  logic [WEIGHT_W-1:0]   wsel;
  logic [WEIGHT_W-1:0]   reload;
  logic [1:0]            start;
  logic                  found;
  logic [1:0]            pick;
  logic                  gnt_v;
  logic                  keep;
  logic [1:0]            gnt;
  logic [CLASS_W-1:0]    dest;
  logic                  push_v;

  // A queue is eligible when it has data and its target has room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = enable & ~empty_in[i]
              & ~almost_full_out[head_class[i*CLASS_W +: CLASS_W]];
    end
  end

  assign start = ptr + 2'd1;

  tl_rr_pick u_pick (
    .elig  (elig),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  // Stay on ptr while it has credit, else rotate from ptr+1.
  always_comb begin
    gnt_v = 1'b0;
    keep  = 1'b0;
    gnt   = ptr;
    if (!reset) begin
      if (elig[ptr] && credit != '0) begin
        gnt_v = 1'b1;
        keep  = 1'b1;
        gnt   = ptr;
      end else if (found) begin
        gnt_v = 1'b1;
        gnt   = pick;
      end
    end
  end

  assign wsel   = weight_of(weight_cfg, gnt);
  assign reload = (wsel == '0) ? '0 : wsel - WEIGHT_W'(1);

  // Next state and the Mealy pop strobe.
  always_comb begin
    state_d = state;
    pop_in  = '0;
    unique case (state)
      IDLE:    if (|elig) state_d = SERVE;
      SERVE:   if (~|elig) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (gnt_v) pop_in = NUM_Q'(1) << gnt;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Pointer and burst credit bookkeeping on each grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= 2'd0;
      credit   <= '0;
      grant_id <= 2'd0;
    end else if (gnt_v) begin
      grant_id <= gnt;
      if (keep) begin
        credit <= credit - WEIGHT_W'(1);
      end else begin
        ptr    <= gnt;
        credit <= reload;
      end
    end
  end

  // Push stage: carry the popped word's class one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_v <= 1'b0;
      dest   <= '0;
    end else begin
      push_v <= gnt_v;
      if (gnt_v) dest <= head_class[gnt*CLASS_W +: CLASS_W];
    end
  end

  assign push_out = push_v ? (NUM_Q'(1) << dest) : '0;

  // Idle once nothing is granted or in flight and inputs are dry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle <= 1'b1;
    else       idle <= ~gnt_v & (&empty_in);
  end

endmodule

// File: tb/tb_tl_wrr_scheduler.sv
// Directed bench for tl_wrr_scheduler with a one-deep
// scoreboard of expected push/grant_id per popped word.
module tb_tl_wrr_scheduler;
  import tl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] weight_cfg = '0;
  logic [3:0]  empty_in = 4'hF;
  logic [7:0]  head_class = '0;
  logic [3:0]  almost_full_out = '0;
  logic [3:0]  pop_in;
  logic [3:0]  push_out;
  logic [1:0]  grant_id;
  logic        idle;

  typedef struct packed {
    logic [3:0] push;
    logic [1:0] gid;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] last_gid = 2'd0;

  tl_wrr_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .weight_cfg      (weight_cfg),
    .empty_in        (empty_in),
    .head_class      (head_class),
    .almost_full_out (almost_full_out),
    .pop_in          (pop_in),
    .push_out        (push_out),
    .grant_id        (grant_id),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hc4(int a, int b, int c, int d);
    return {d[1:0], c[1:0], b[1:0], a[1:0]};
  endfunction

  function automatic logic [11:0] w4(int a, int b, int c, int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  function automatic logic [1:0] oh2i(logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      oh[0]: r = 2'd0;
      oh[1]: r = 2'd1;
      oh[2]: r = 2'd2;
      oh[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check pop now, check last cycle's push/grant_id,
  // queue the push/grant_id this pop must produce next cycle.
  task automatic cyc(string tag, logic [3:0] exp_pop);
    exp_t e;
    exp_t o;
    logic [1:0] hc;
    @(negedge clk);
    chk({tag, "/pop"}, {4'h0, pop_in}, {4'h0, exp_pop});
    o = '0;
    if (sb.size() > 0) o = sb.pop_front();
    chk({tag, "/push"}, {4'h0, push_out}, {4'h0, o.push});
    chk({tag, "/gid"}, {6'h0, grant_id}, {6'h0, o.gid});
    e = '0;
    if (exp_pop != 4'h0) begin
      last_gid = oh2i(exp_pop);
      hc = head_class[last_gid*2 +: 2];
      e.push = 4'b0001 << hc;
    end
    e.gid = last_gid;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Hold reset for n cycles with enable low, then release.
  task automatic do_reset(string tag, int n);
    @(posedge clk);
    #1;
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "/rpop"}, {4'h0, pop_in}, 8'h00);
      chk({tag, "/rpush"}, {4'h0, push_out}, 8'h00);
      chk({tag, "/ridle"}, {7'h0, idle}, 8'h01);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    sb.push_back('0);
    last_gid = 2'd0;
  endtask

  initial begin
    logic [3:0] t2[14];
    t2 = '{4'h2, 4'h4, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1,
           4'h2, 4'h4, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1};

    // Reset with full inputs, then plain rotation at weight 1.
    empty_in   = 4'h0;
    head_class = hc4(3, 2, 1, 0);
    weight_cfg = w4(1, 1, 1, 1);
    do_reset("t1", 10);
    chk("t1/idle_rel", {7'h0, idle}, 8'h00);
    cyc("t1/off", 4'h0);
    enable = 1'b1;
    cyc("t1a", 4'h2);
    cyc("t1b", 4'h4);
    cyc("t1c", 4'h8);
    cyc("t1d", 4'h1);
    cyc("t1e", 4'h2);
    enable = 1'b0;
    cyc("t1f", 4'h0);

    // Weighted burst pattern; weight 0 behaves as 1.
    head_class = hc4(0, 1, 2, 3);
    weight_cfg = w4(3, 1, 2, 0);
    do_reset("t2", 2);
    enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc("t2", t2[i]);
      chk("t2/idle", {7'h0, idle}, 8'h00);
    end
    enable = 1'b0;
    cyc("t2f", 4'h0);

    // Lone eligible queue is granted back-to-back.
    head_class = hc4(0, 1, 1, 3);
    weight_cfg = w4(1, 1, 2, 1);
    empty_in   = 4'b1011;
    do_reset("t3", 2);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cyc("t3", 4'h4);
    chk("t3/gid", {6'h0, grant_id}, 8'h02);
    enable = 1'b0;
    cyc("t3f", 4'h0);

    // Almost-full destination skips q1 until it clears.
    head_class      = hc4(0, 3, 2, 1);
    weight_cfg      = w4(1, 1, 1, 1);
    empty_in        = 4'b1000;
    almost_full_out = 4'b1000;
    do_reset("t4", 2);
    enable = 1'b1;
    cyc("t4a", 4'h4);
    cyc("t4b", 4'h1);
    cyc("t4c", 4'h4);
    cyc("t4d", 4'h1);
    almost_full_out = 4'b0000;
    cyc("t4e", 4'h2);
    cyc("t4f", 4'h4);
    cyc("t4g", 4'h1);
    cyc("t4h", 4'h2);

    // Enable drops right after a pop: push completes, no more pops.
    enable = 1'b0;
    cyc("t5a", 4'h0);
    cyc("t5b", 4'h0);
    chk("t5/idle0", {7'h0, idle}, 8'h00);
    empty_in = 4'hF;
    cyc("t5c", 4'h0);
    chk("t5/idle1", {7'h0, idle}, 8'h01);

    // Reset lands while a push is in flight.
    empty_in   = 4'b1110;
    head_class = hc4(0, 0, 0, 0);
    enable     = 1'b1;
    cyc("t6", 4'h1);
    chk("t6/inflight", {4'h0, push_out}, 8'h01);
    reset = 1'b1;
    #1;
    chk("t6/push", {4'h0, push_out}, 8'h00);
    chk("t6/pop", {4'h0, pop_in}, 8'h00);
    chk("t6/gid", {6'h0, grant_id}, 8'h00);
    chk("t6/idle", {7'h0, idle}, 8'h01);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
